// File: rtl/game_select_mux.sv
// Active-game selector for the seven-segment games top level: cycles the selection over the
// enabled games, gates button pulses to the active game and muxes its value or number to the display.
module game_select_mux #(
    parameter int          NUM_GAMES   = 4,
    parameter int          NUM_BTNS    = 4,
    parameter int          VAL_W       = 4,
    parameter logic [23:0] SHOW_CYCLES = 24'd12_000_000,
    parameter int          BLANK_CODE  = 12,
    localparam int         SEL_W       = (NUM_GAMES > 2) ? $clog2(NUM_GAMES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          switch_pulse,
    input  logic [NUM_BTNS-1:0]           btn_pulse,
    input  logic [NUM_GAMES-1:0]          game_enable,
    input  logic [NUM_GAMES*VAL_W-1:0]    game_values,
    output logic [SEL_W-1:0]              game_sel,
    output logic [NUM_GAMES*NUM_BTNS-1:0] btn_route,
    output logic [VAL_W-1:0]              display_value,
    output logic                          showing_index
);

    localparam int CNT_W = (SHOW_CYCLES == 24'd0) ? 1 : $clog2(int'(SHOW_CYCLES) + 1);
    localparam int SLOTS = 1 << SEL_W;
    localparam logic [CNT_W-1:0] SHOW_LOAD = CNT_W'(SHOW_CYCLES);
    localparam logic [VAL_W-1:0] BLANK_V   = VAL_W'(BLANK_CODE);

    if (NUM_GAMES < 2 || NUM_GAMES > 8 || NUM_BTNS < 1 || NUM_BTNS > 7 ||
        (1 << VAL_W) <= NUM_GAMES) begin : g_bad_params
        $error("game_select_mux: illegal parameter combination");
    end

    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] nxt;
    logic [SEL_W-1:0] cand;
    logic [CNT_W-1:0] show_cnt;
    logic [SLOTS-1:0] en_pad;
    logic [VAL_W-1:0] val_pad [SLOTS];
    logic             found;
    logic             none_en;
    logic             sel_en;
    logic             showing;
    logic             route_ok;

    // Tables padded to a power of two so an out-of-range sel reads as a disabled, zero-valued slot.
    always_comb begin
        en_pad = '0;
        en_pad[NUM_GAMES-1:0] = game_enable;
        for (int g = 0; g < SLOTS; g++) begin
            val_pad[g] = '0;
        end
        for (int g = 0; g < NUM_GAMES; g++) begin
            val_pad[g] = game_values[g*VAL_W +: VAL_W];
        end
    end

    assign none_en = ~|game_enable;
    assign sel_en  = en_pad[sel];
    assign showing = (show_cnt != '0);

    // Circular search starting just after sel and ending on sel itself.
    always_comb begin
        nxt   = sel;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_GAMES; k++) begin
            cand = SEL_W'((int'(sel) + k) % NUM_GAMES);
            if (!found && en_pad[cand]) begin
                nxt   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel      <= '0;
            show_cnt <= '0;
        end else if (none_en) begin
            show_cnt <= '0;
        end else if (switch_pulse || !sel_en) begin
            sel      <= nxt;
            show_cnt <= SHOW_LOAD;
        end else if (showing) begin
            show_cnt <= show_cnt - CNT_W'(1);
        end
    end

    assign route_ok = sel_en && !showing && !switch_pulse;

    always_comb begin
        btn_route = '0;
        for (int g = 0; g < NUM_GAMES; g++) begin
            if (route_ok && sel == SEL_W'(g)) begin
                btn_route[g*NUM_BTNS +: NUM_BTNS] = btn_pulse;
            end
        end
    end

    always_comb begin
        if (none_en) begin
            display_value = BLANK_V;
        end else if (showing) begin
            display_value = VAL_W'(sel) + VAL_W'(1);
        end else begin
            display_value = val_pad[sel];
        end
    end

    assign game_sel      = sel;
    assign showing_index = showing;

endmodule

// File: tb/tb_game_select_mux.sv
// Bench for game_select_mux: two instances (show length 3 and 0) driven in lockstep and
// compared every cycle with a rule-level model, plus directed checks of the key scenarios.
module tb_game_select_mux;

    localparam int NG = 4;
    localparam int NB = 4;
    localparam int VW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              switch_pulse;
    logic [NB-1:0]     btn_pulse;
    logic [NG-1:0]     game_enable;
    logic [NG*VW-1:0]  game_values;
    logic [1:0]        sel_a, sel_b;
    logic [NG*NB-1:0]  route_a, route_b;
    logic [VW-1:0]     disp_a, disp_b;
    logic              show_a, show_b;

    int total = 0;
    int bad   = 0;
    int m_sel  [2];
    int m_show [2];
    int s_len  [2];
    int seq    [5];
    int held;

    game_select_mux #(.NUM_GAMES(NG), .NUM_BTNS(NB), .VAL_W(VW),
                      .SHOW_CYCLES(24'd3), .BLANK_CODE(12)) dut_a (
        .clk(clk), .reset(reset), .switch_pulse(switch_pulse), .btn_pulse(btn_pulse),
        .game_enable(game_enable), .game_values(game_values), .game_sel(sel_a),
        .btn_route(route_a), .display_value(disp_a), .showing_index(show_a));

    game_select_mux #(.NUM_GAMES(NG), .NUM_BTNS(NB), .VAL_W(VW),
                      .SHOW_CYCLES(24'd0), .BLANK_CODE(12)) dut_b (
        .clk(clk), .reset(reset), .switch_pulse(switch_pulse), .btn_pulse(btn_pulse),
        .game_enable(game_enable), .game_values(game_values), .game_sel(sel_b),
        .btn_route(route_b), .display_value(disp_b), .showing_index(show_b));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_en(input int s, input logic [NG-1:0] en);
        for (int off = 1; off <= NG; off++) begin
            if (en[(s + off) % NG]) return (s + off) % NG;
        end
        return -1;
    endfunction

    task automatic check_all();
        logic [1:0]       o_sel;
        logic [NG*NB-1:0] o_rt, e_rt;
        logic [VW-1:0]    o_d, e_d;
        logic             o_s;
        bit               none;
        none = (game_enable == '0);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_sel[i]  = 0;
                m_show[i] = 0;
            end
            o_sel = (i == 0) ? sel_a   : sel_b;
            o_rt  = (i == 0) ? route_a : route_b;
            o_d   = (i == 0) ? disp_a  : disp_b;
            o_s   = (i == 0) ? show_a  : show_b;
            if (none)            e_d = VW'(12);
            else if (m_show[i] > 0) e_d = VW'(m_sel[i] + 1);
            else                 e_d = game_values[m_sel[i]*VW +: VW];
            e_rt = '0;
            if (!none && game_enable[m_sel[i]] && m_show[i] == 0 && !switch_pulse)
                e_rt[m_sel[i]*NB +: NB] = btn_pulse;
            chk($sformatf("sel%0d", i),   32'(o_sel), 32'(m_sel[i]));
            chk($sformatf("show%0d", i),  32'(o_s),   32'(m_show[i] > 0));
            chk($sformatf("disp%0d", i),  32'(o_d),   32'(e_d));
            chk($sformatf("route%0d", i), 32'(o_rt),  32'(e_rt));
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_sel[i]  = 0;
                m_show[i] = 0;
            end else if (game_enable == '0) begin
                m_show[i] = 0;
            end else if (switch_pulse || !game_enable[m_sel[i]]) begin
                m_sel[i]  = next_en(m_sel[i], game_enable);
                m_show[i] = s_len[i];
            end else if (m_show[i] > 0) begin
                m_show[i]--;
            end
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cyc();
        #1 check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc();
    endtask

    initial begin
        s_len[0] = 3;  s_len[1] = 0;
        m_sel[0] = 0;  m_sel[1] = 0;
        m_show[0] = 0; m_show[1] = 0;
        seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;
        reset = 1'b1; switch_pulse = 1'b0; btn_pulse = '0;
        game_enable = 4'hF; game_values = 16'h9753;

        @(negedge clk);
        #1;
        chk("rst_sel",   32'(sel_a),   32'd0);
        chk("rst_show",  32'(show_a),  32'd0);
        chk("rst_route", 32'(route_a), 32'd0);
        chk("rst_disp",  32'(disp_a),  32'd3);
        reset = 1'b0;
        cyc();

        // Wrap cycling over all four games.
        for (int k = 0; k < 5; k++) begin
            switch_pulse = 1'b1;
            cyc();
            switch_pulse = 1'b0;
            for (int c = 0; c < 10; c++) begin
                #1;
                if (c < 3) begin
                    chk("wrap_sel",  32'(sel_a),  32'(seq[k]));
                    chk("wrap_show", 32'(show_a), 32'd1);
                    chk("wrap_disp", 32'(disp_a), 32'(seq[k] + 1));
                end else if (c == 3) begin
                    chk("wrap_end", 32'(show_a), 32'd0);
                end
                cyc();
            end
        end

        // Skip mask 1010 starting from game 1.
        game_enable = 4'b1010;
        switch_pulse = 1'b1;
        cyc();
        switch_pulse = 1'b0;
        #1 chk("skip_1to3", 32'(sel_a), 32'd3);
        idle(5);
        switch_pulse = 1'b1;
        cyc();
        switch_pulse = 1'b0;
        #1 chk("skip_3to1", 32'(sel_a), 32'd1);
        idle(5);
        game_enable = 4'b1000;
        cyc();
        #1;
        chk("dis_sel",  32'(sel_a),  32'd3);
        chk("dis_show", 32'(show_a), 32'd1);
        idle(5);

        // Button gating on game 2.
        game_enable = 4'b0100;
        cyc();
        game_enable = 4'hF;
        btn_pulse = 4'b0001;
        #1 chk("gate_show", 32'(route_a), 32'd0);
        cyc();
        btn_pulse = '0;
        idle(2);
        btn_pulse = 4'b0010;
        #1 chk("gate_open", 32'(route_a), 32'h0200);
        cyc();
        btn_pulse = '0;
        #1 chk("gate_once", 32'(route_a), 32'd0);
        cyc();
        switch_pulse = 1'b1;
        btn_pulse = 4'hF;
        #1;
        chk("coinc_a", 32'(route_a), 32'd0);
        chk("coinc_b", 32'(route_b), 32'd0);
        cyc();
        switch_pulse = 1'b0;

        // No enabled games while showing.
        game_enable = '0;
        #1;
        chk("none_disp",  32'(disp_a),  32'd12);
        chk("none_route", 32'(route_a), 32'd0);
        cyc();
        #1 chk("none_show", 32'(show_a), 32'd0);
        held = int'(sel_a);
        switch_pulse = 1'b1;
        cyc();
        switch_pulse = 1'b0;
        #1 chk("none_hold", 32'(sel_a), 32'(held));
        game_enable = 4'b0100;
        btn_pulse = '0;
        cyc();
        #1;
        chk("reen_sel",  32'(sel_a),  32'd2);
        chk("reen_show", 32'(show_a), 32'd1);

        // Asynchronous reset with sel=3 and two show cycles left.
        game_enable = 4'hF;
        switch_pulse = 1'b1;
        cyc();
        switch_pulse = 1'b0;
        cyc();
        #1 chk("pre_rst_sel", 32'(sel_a), 32'd3);
        reset = 1'b1;
        #1;
        chk("arst_sel",  32'(sel_a),  32'd0);
        chk("arst_show", 32'(show_a), 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        #1 chk("post_disp_b", 32'(disp_b), 32'd3);
        switch_pulse = 1'b1;
        cyc();
        switch_pulse = 1'b0;
        btn_pulse = 4'b0001;
        #1 chk("post_route_b", 32'(route_b), 32'h0010);
        cyc();
        btn_pulse = '0;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            reset        = ($urandom_range(0, 96) == 0);
            switch_pulse = ($urandom_range(0, 5) == 0);
            btn_pulse    = NB'($urandom);
            game_values  = (NG*VW)'($urandom);
            if ($urandom_range(0, 11) == 0)
                game_enable = ($urandom_range(0, 3) == 0) ? '0 : NG'($urandom);
            cyc();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_select_mux.md
# game_select_mux

Parametrised game selector and display/button router for the seven-segment games top level. It holds the active game index and cycles it on a switch pulse, skipping games masked off by `game_enable`. It routes debounced button pulses only to the active game and multiplexes that game's value to the 7-seg driver. After each switch, it briefly shows the new game number (1-based) with buttons blocked.

## Interface
Parameters:
- `NUM_GAMES`, default 4: number of game slots, legal range 2..8.
- `NUM_BTNS`, default 4: number of game buttons, legal range 1..7.
- `VAL_W`, default 4: display value width. Must satisfy 2^VAL_W > NUM_GAMES.
- `SHOW_CYCLES`, default 24'd12_000_000: length of the game-number display after a switch. 0 disables it.
- `BLANK_CODE`, default 12: driver code that blanks the 7-seg.

Ports:
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, asynchronous, active-high.
- `switch_pulse`, input, 1: one-cycle pulse that advances the game.
- `btn_pulse`, input, NUM_BTNS: one-cycle button pulses from the button modules.
- `game_enable`, input, NUM_GAMES: bit g=1 means game g is selectable. May change at any time.
- `game_values`, input, NUM_GAMES*VAL_W: game g's value on bits [g*VAL_W +: VAL_W].
- `game_sel`, output, SEL_W: active game index, where SEL_W = max(1, $clog2(NUM_GAMES)).
- `btn_route`, output, NUM_GAMES*NUM_BTNS: routed pulses. Game g receives its pulses on bits [g*NUM_BTNS +: NUM_BTNS].
- `display_value`, output, VAL_W: value to the sevenseg driver.
- `showing_index`, output, 1: high while the game number is shown.

## Operation
- State consists of the registered `sel` (SEL_W bits) and `show_cnt` (width $clog2(SHOW_CYCLES+1)). `showing_index` = (show_cnt != 0).
- Next-enabled scan (combinational): search indices sel+1, sel+2, … modulo NUM_GAMES, ending at sel itself. The first index with `game_enable` set is `nxt`. If no bit is set, `none_en` = 1.
- Update priority, evaluated each cycle and highest first:
  1. `none_en`: sel holds and show_cnt is cleared to 0.
  2. `switch_pulse`: sel <= nxt and show_cnt <= SHOW_CYCLES. This applies even while showing, which restarts the show on the next game. If sel is the only enabled game, sel stays and the show restarts.
  3. `game_enable[sel]` == 0 (the active game was disabled): sel <= nxt and show_cnt <= SHOW_CYCLES.
  4. Otherwise: if show_cnt != 0, show_cnt decrements by 1.
- Button routing (combinational): for every game g and button b, btn_route[g*NUM_BTNS+b] = btn_pulse[b] & (sel==g) & game_enable[g] & !showing_index & !switch_pulse.
  - A button pulse coincident with `switch_pulse` is dropped for every game.
  - Every pulse that arrives while the game number is shown is dropped.
- Display mux (combinational), in priority order:
  1. `none_en` gives BLANK_CODE.
  2. `showing_index` gives sel+1, zero-extended to VAL_W.
  3. Otherwise the display shows game_values[sel*VAL_W +: VAL_W].
- If sel ≥ NUM_GAMES (unreachable in normal operation), treat sel as disabled and recover via rule 3.

## Timing
- Reset values:
  - sel = 0 and show_cnt = 0.
  - game_sel = 0 and showing_index = 0.
  - btn_route = 0.
  - display_value = game_values[0 +: VAL_W], or BLANK_CODE if `none_en`.
- If game 0 is disabled at reset release, the first clock edge moves sel to the first enabled game and starts the show.
- `switch_pulse` sampled at edge N: game_sel and showing_index change after edge N, and are visible in cycle N+1.
- With SHOW_CYCLES = S > 0, showing_index is high for exactly S cycles after the switch edge, then falls. Routing resumes in the first cycle in which it is low.
- With SHOW_CYCLES = 0, show_cnt stays 0. Buttons route from cycle N+1 and the display goes straight to the game value.
- btn_route and display_value are combinational from registered state and the current inputs, with zero latency. Downstream games register them.
- Wrap-around: a switch from index NUM_GAMES-1 goes to the lowest enabled index.
- Asserting reset mid-show clears the show immediately (asynchronously) and returns sel to 0.

## Test plan
- Wrap cycling: NUM_GAMES=4, SHOW_CYCLES=3, all games enabled. Apply 5 switch pulses spaced 10 cycles apart. Required: game_sel goes 1,2,3,0,1, and showing_index is high for exactly 3 cycles after each pulse. During each show, display_value is 2,3,4,1,2.
- Skip mask: game_enable=4'b1010 and sel=1. Apply a switch pulse. Required: game_sel=3. A second switch gives game_sel=1. Then clear bit 1: sel moves to 3 on the next edge and the show starts.
- Button gating: sel=2, showing. Pulse btn_pulse[0]. Required: btn_route stays all zero. After the show, a pulse on btn_pulse[1] sets only btn_route[2*NUM_BTNS+1] for exactly 1 cycle. A pulse coincident with switch_pulse is dropped.
- No enabled games: set game_enable=0 during a show. Required: display_value=BLANK_CODE (12), showing_index=0 next cycle, btn_route=0, and switch pulses are ignored. Re-enable only game 2: sel becomes 2 next edge and the show starts.
- Reset mid-show: assert reset asynchronously between edges while show_cnt=2 and sel=3. Required: game_sel=0 and showing_index=0 immediately. After release, display_value follows game_values[3:0] with SHOW_CYCLES=0 in a second configuration run, and a switch makes buttons route in the next cycle.
